layer3_ctrl: RTL and testbench



---
 rtl/layer3_ctrl_pkg.sv | 28 ++
 rtl/layer3_ctrl_argmax_tracker.sv | 43 ++++
 rtl/layer3_ctrl.sv | 171 +++++++++++++++++
 tb/tb_layer3_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer3_ctrl_pkg.sv
// rtl/layer3_ctrl_pkg.sv - shared constants, state encoding and width helper for layer3_ctrl
//
// Purpose: single source of truth for the output-layer geometry (64 inputs per
// neuron, 10 neurons), the controller state encoding and the derived widths.
package layer3_ctrl_pkg;

  localparam int N_IN  = 64;
  localparam int N_OUT = 10;

  // Address/index width for a table of `depth` entries (never below 1 bit).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int K_W      = addr_w(N_IN);
  localparam int N_W      = addr_w(N_OUT);
  localparam int W_ADDR_W = addr_w(N_IN * N_OUT);
  localparam int CLASS_W  = N_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_t;

endpackage

// File: rtl/layer3_ctrl_argmax_tracker.sv
// rtl/layer3_ctrl_argmax_tracker.sv - running signed argmax over the output logits
//
// Purpose: keeps the best (index, value) pair seen so far. load_i forces the
// first sample in; later samples replace it only when strictly greater, so a
// tie keeps the lower index.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        take value_i unconditionally (first neuron)
//   cmp_en_i      a logit sample is present this cycle
//   idx_i         neuron index of the sample
//   value_i       signed logit
//   class_o       index of the current maximum
//   max_o         current maximum value
module layer3_ctrl_argmax_tracker
  import layer3_ctrl_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               cmp_en_i,
  input  logic [CLASS_W-1:0] idx_i,
  input  logic [ACC_W-1:0]   value_i,
  output logic [CLASS_W-1:0] class_o,
  output logic [ACC_W-1:0]   max_o
);

  logic better;

  assign better = $signed(value_i) > $signed(max_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      class_o <= '0;
      max_o   <= '0;
    end else if (cmp_en_i && (load_i || better)) begin
      class_o <= idx_i;
      max_o   <= value_i;
    end
  end

endmodule

// File: rtl/layer3_ctrl.sv
// rtl/layer3_ctrl.sv - output-layer controller: streams 64x10 MAC terms, reports argmax class
//
// Purpose: on start, walks neurons n=0..9; for each one streams k=0..63 into the
// shared MAC, drains the read+MAC latency, samples the logit and feeds the
// argmax tracker. Reports the winning class/logit with a one-cycle done pulse.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             start pulse, only honoured in IDLE
//   x_addr_o, x_en_o    activation buffer read (address k)
//   w_addr_o, w_en_o    weight ROM read (address n*64+k)
//   mac_en_o            accumulate enable, read enable delayed by RD_LAT
//   mac_clear_o         marks the k=0 term so the MAC loads instead of adds
//   acc_i               signed MAC result
//   busy_o              high while a run is in progress, low in the done cycle
//   class_o, max_o      result, held until the next run completes
//   done_o              one-cycle completion pulse
module layer3_ctrl
  import layer3_ctrl_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic [K_W-1:0]      x_addr_o,
  output logic                x_en_o,
  output logic [W_ADDR_W-1:0] w_addr_o,
  output logic                w_en_o,
  output logic                mac_en_o,
  output logic                mac_clear_o,
  input  logic [ACC_W-1:0]    acc_i,
  output logic                busy_o,
  output logic [CLASS_W-1:0]  class_o,
  output logic [ACC_W-1:0]    max_o,
  output logic                done_o
);

  localparam int DRAIN_CYC = RD_LAT + MAC_LAT;
  localparam int DC_W      = addr_w(DRAIN_CYC);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(N_IN - 1);
  localparam logic [N_W-1:0]  N_LAST  = N_W'(N_OUT - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_CYC - 1);

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_q;
  logic [N_W-1:0]     n_q;
  logic [DC_W-1:0]    dc_q;
  logic [RD_LAT-1:0]  en_dly_q, clr_dly_q;
  logic [CLASS_W-1:0] trk_class, class_q;
  logic [ACC_W-1:0]   trk_max, max_q;
  logic               last_k, last_n, cmp_en;

  assign last_k = (k_q == K_LAST);
  assign last_n = (n_q == N_LAST);
  assign cmp_en = (state_q == S_CMP);

  always_comb begin
    state_d  = state_q;
    x_en_o   = 1'b0;
    w_en_o   = 1'b0;
    x_addr_o = '0;
    w_addr_o = '0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        x_en_o   = 1'b1;
        w_en_o   = 1'b1;
        x_addr_o = k_q;
        w_addr_o = W_ADDR_W'(n_q) * W_ADDR_W'(N_IN) + W_ADDR_W'(k_q);
        busy_o   = 1'b1;
        if (last_k) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        if (dc_q == DC_LAST) state_d = S_CMP;
      end
      S_CMP: begin
        busy_o  = 1'b1;
        state_d = last_n ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            k_q <= '0;
            n_q <= '0;
          end
        end
        S_FETCH: begin
          k_q  <= last_k ? '0 : k_q + K_W'(1);
          dc_q <= '0;
        end
        S_DRAIN: dc_q <= dc_q + DC_W'(1);
        S_CMP: begin
          if (!last_n) begin
            n_q <= n_q + N_W'(1);
            k_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-latency delay line: the MAC sees enable/clear when the memory data lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_dly_q  <= '0;
      clr_dly_q <= '0;
    end else begin
      en_dly_q[0]  <= x_en_o;
      clr_dly_q[0] <= x_en_o && (k_q == '0);
      for (int i = 1; i < RD_LAT; i++) begin
        en_dly_q[i]  <= en_dly_q[i-1];
        clr_dly_q[i] <= clr_dly_q[i-1];
      end
    end
  end

  assign mac_en_o    = en_dly_q[RD_LAT-1];
  assign mac_clear_o = clr_dly_q[RD_LAT-1];

  layer3_ctrl_argmax_tracker #(.ACC_W(ACC_W)) u_argmax (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (n_q == '0),
    .cmp_en_i (cmp_en),
    .idx_i    (CLASS_W'(n_q)),
    .value_i  (acc_i),
    .class_o  (trk_class),
    .max_o    (trk_max)
  );

  // The tracker starts overwriting at the first compare of a new run, so the
  // visible result is latched at done and shown straight from the tracker
  // during the done cycle itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      class_q <= '0;
      max_q   <= '0;
    end else if (state_q == S_DONE) begin
      class_q <= trk_class;
      max_q   <= trk_max;
    end
  end

  assign class_o = (state_q == S_DONE) ? trk_class : class_q;
  assign max_o   = (state_q == S_DONE) ? trk_max   : max_q;

endmodule

// File: tb/tb_layer3_ctrl.sv
// tb/tb_layer3_ctrl.sv - self-checking bench for layer3_ctrl with memory/MAC model
module tb_layer3_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  x_addr_o;
  logic        x_en_o;
  logic [9:0]  w_addr_o;
  logic        w_en_o, mac_en_o, mac_clear_o;
  logic [31:0] acc_i;
  logic        busy_o;
  logic [3:0]  class_o;
  logic [31:0] max_o;
  logic        done_o;

  always #5 clk = ~clk;

  layer3_ctrl #(.ACC_W(32), .RD_LAT(1), .MAC_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .x_addr_o(x_addr_o), .x_en_o(x_en_o), .w_addr_o(w_addr_o), .w_en_o(w_en_o),
    .mac_en_o(mac_en_o), .mac_clear_o(mac_clear_o), .acc_i(acc_i),
    .busy_o(busy_o), .class_o(class_o), .max_o(max_o), .done_o(done_o)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories with one-cycle read latency and a load/accumulate MAC.
  logic signed [31:0] xmem [64];
  logic signed [31:0] wmem [640];
  logic signed [31:0] x_q, w_q, acc;
  always @(posedge clk) begin
    if (rst_i) begin
      x_q <= 0; w_q <= 0; acc <= 0;
    end else begin
      x_q <= x_en_o ? xmem[x_addr_o] : 32'sd0;
      w_q <= w_en_o ? wmem[w_addr_o] : 32'sd0;
      if (mac_en_o) acc <= (mac_clear_o ? 32'sd0 : acc) + x_q * w_q;
    end
  end
  assign acc_i = acc;

  // Reference: logits chosen up front, memory contents solved so each neuron's
  // dot product equals its logit, argmax found by a plain first-wins scan.
  logic signed [31:0] logits [10];
  int                 exp_class;
  logic signed [31:0] exp_max;

  task automatic build_model();
    logic signed [31:0] s;
    exp_class = 0;
    exp_max = logits[0];
    for (int n = 1; n < 10; n++)
      if (logits[n] > exp_max) begin exp_class = n; exp_max = logits[n]; end
    for (int k = 0; k < 63; k++) xmem[k] = 32'($urandom_range(3, 1));
    xmem[63] = 32'sd1;
    for (int n = 0; n < 10; n++) begin
      s = 0;
      for (int k = 0; k < 63; k++) begin
        wmem[n*64+k] = 32'($urandom_range(100, 0)) - 32'sd50;
        s = s + xmem[k] * wmem[n*64+k];
      end
      wmem[n*64+63] = logits[n] - s;
    end
  endtask

  // Run statistics gathered mid-cycle.
  int   w_seq, seq_err, clr_cnt, done_cnt, done_cyc, busy_err, t_start;
  bit   run_on = 1'b0;
  logic busy_at_done;
  logic [3:0]  class_at_done;
  logic [31:0] max_at_done;

  always @(negedge clk) begin
    if (w_en_o === 1'b1) begin
      if (w_addr_o !== 10'(w_seq) || x_addr_o !== 6'(w_seq % 64) || x_en_o !== 1'b1) seq_err++;
      w_seq++;
    end
    if (mac_clear_o === 1'b1) clr_cnt++;
    if (done_o === 1'b1) begin
      done_cnt++;
      if (done_cnt == 1) begin
        done_cyc = cyc; busy_at_done = busy_o; class_at_done = class_o; max_at_done = max_o;
      end
    end
    if (run_on && cyc > t_start && cyc < t_start + 671 && busy_o !== 1'b1) busy_err++;
  end

  task automatic clear_stats();
    w_seq = 0; seq_err = 0; clr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_err = 0;
    busy_at_done = 1'b1; class_at_done = 4'hf; max_at_done = 32'hffffffff;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    clear_stats();
    start_i = 1'b1;
    t_start = cyc;
    run_on = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    #1;
    total++;
    if (done_o !== 1'b1) begin bad++; $display("FAIL %s_done_timeout: done_o=%b required 1", name, done_o); end
  endtask

  task automatic small_random_logits();
    for (int n = 0; n < 10; n++) logits[n] = 32'($urandom_range(1000, 0)) - 32'sd500;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({x_addr_o, x_en_o, w_addr_o, w_en_o, mac_en_o, mac_clear_o, busy_o, class_o, max_o, done_o} !== '0) begin
      bad++; $display("FAIL reset_init: outputs=%h required 0", {x_addr_o, x_en_o, w_addr_o, w_en_o, mac_en_o, mac_clear_o, busy_o, class_o, max_o, done_o});
    end
    rst_i = 1'b0;
    small_random_logits();
    build_model();
    pulse_start();
    while (cyc < t_start + 30) @(negedge clk);
    total++;
    if (busy_o !== 1'b1 || w_en_o !== 1'b1) begin bad++; $display("FAIL reset_midrun_active: busy=%b w_en=%b required 1 1", busy_o, w_en_o); end
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({x_addr_o, x_en_o, w_addr_o, w_en_o, mac_en_o, mac_clear_o, busy_o, class_o, max_o, done_o} !== '0) begin
      bad++; $display("FAIL reset_midrun: outputs=%h required 0", {x_addr_o, x_en_o, w_addr_o, w_en_o, mac_en_o, mac_clear_o, busy_o, class_o, max_o, done_o});
    end
    rst_i = 1'b0;
    run_on = 1'b0;
    clear_stats();
    repeat (700) @(negedge clk);
    #1;
    total++;
    if (done_cnt != 0 || busy_o !== 1'b0 || w_seq != 0) begin
      bad++; $display("FAIL reset_quiet: done_cnt=%0d busy=%b reads=%0d required 0 0 0", done_cnt, busy_o, w_seq);
    end
  endtask

  task automatic test_nominal();
    logits = '{-5, 3, 12, 7, 0, -1, 11, 2, 9, 4};
    build_model();
    pulse_start();
    wait_done("nominal");
    repeat (3) @(negedge clk);
    #1;
    total++; if (done_cyc != t_start + 671) begin bad++; $display("FAIL nominal_done_cycle: got T+%0d required T+671", done_cyc - t_start); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL nominal_done_count: got %0d required 1", done_cnt); end
    total++; if (class_at_done !== 4'(exp_class)) begin bad++; $display("FAIL nominal_class: got %0d required %0d", class_at_done, exp_class); end
    total++; if (max_at_done !== exp_max) begin bad++; $display("FAIL nominal_max: got %0d required %0d", $signed(max_at_done), exp_max); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL nominal_busy_at_done: got %b required 0", busy_at_done); end
    total++; if (busy_err != 0) begin bad++; $display("FAIL nominal_busy_window: got %0d low cycles required 0", busy_err); end
    total++; if (seq_err != 0 || w_seq != 640) begin bad++; $display("FAIL nominal_addr_seq: errors=%0d reads=%0d required 0 640", seq_err, w_seq); end
    total++; if (clr_cnt != 10) begin bad++; $display("FAIL nominal_clear_count: got %0d required 10", clr_cnt); end
    total++; if (class_o !== 4'(exp_class) || max_o !== exp_max) begin bad++; $display("FAIL nominal_hold: got %0d/%0d required %0d/%0d", class_o, $signed(max_o), exp_class, exp_max); end
  endtask

  task automatic test_tie();
    for (int n = 0; n < 10; n++) logits[n] = 32'($urandom_range(57, 0)) - 32'sd50;
    logits[3] = 8;
    logits[7] = 8;
    build_model();
    pulse_start();
    wait_done("tie");
    total++; if (class_at_done !== 4'(exp_class)) begin bad++; $display("FAIL tie_class: got %0d required %0d", class_at_done, exp_class); end
    total++; if (max_at_done !== exp_max) begin bad++; $display("FAIL tie_max: got %0d required %0d", $signed(max_at_done), exp_max); end
  endtask

  task automatic test_all_negative();
    for (int n = 0; n < 10; n++) logits[n] = -32'sd100 + n;
    build_model();
    pulse_start();
    wait_done("neg");
    total++; if (class_at_done !== 4'(exp_class)) begin bad++; $display("FAIL neg_class: got %0d required %0d", class_at_done, exp_class); end
    total++; if (max_at_done !== exp_max) begin bad++; $display("FAIL neg_max: got %0d required %0d", $signed(max_at_done), exp_max); end
  endtask

  task automatic test_random();
    int i, j;
    for (int it = 0; it < 4; it++) begin
      for (int n = 0; n < 10; n++) logits[n] = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        i = $urandom_range(9, 0);
        j = $urandom_range(9, 0);
        logits[j] = logits[i];
      end
      build_model();
      pulse_start();
      wait_done("random");
      total++; if (class_at_done !== 4'(exp_class)) begin bad++; $display("FAIL random_class it%0d: got %0d required %0d", it, class_at_done, exp_class); end
      total++; if (max_at_done !== exp_max) begin bad++; $display("FAIL random_max it%0d: got %0d required %0d", it, $signed(max_at_done), exp_max); end
      total++; if (seq_err != 0 || clr_cnt != 10) begin bad++; $display("FAIL random_stream it%0d: errors=%0d clears=%0d required 0 10", it, seq_err, clr_cnt); end
    end
  endtask

  task automatic test_start_during_busy();
    small_random_logits();
    build_model();
    pulse_start();
    while (cyc < t_start + 200) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("busy_start");
    repeat (5) @(negedge clk);
    #1;
    total++; if (done_cyc != t_start + 671) begin bad++; $display("FAIL busy_start_done_cycle: got T+%0d required T+671", done_cyc - t_start); end
    total++; if (done_cnt != 1 || clr_cnt != 10) begin bad++; $display("FAIL busy_start_single: dones=%0d clears=%0d required 1 10", done_cnt, clr_cnt); end
    total++; if (class_at_done !== 4'(exp_class) || max_at_done !== exp_max) begin
      bad++; $display("FAIL busy_start_result: got %0d/%0d required %0d/%0d", class_at_done, $signed(max_at_done), exp_class, exp_max);
    end
  endtask

  task automatic test_back_to_back();
    int                 c1;
    logic signed [31:0] m1;
    small_random_logits();
    build_model();
    pulse_start();
    wait_done("b2b_first");
    c1 = exp_class;
    m1 = exp_max;
    total++; if (class_at_done !== 4'(c1) || max_at_done !== m1) begin
      bad++; $display("FAIL b2b_first_result: got %0d/%0d required %0d/%0d", class_at_done, $signed(max_at_done), c1, m1);
    end
    // Start raised in the done cycle (ignored) and held into the next IDLE cycle (accepted).
    start_i = 1'b1;
    small_random_logits();
    logits[(c1 + 5) % 10] = 32'sd1000;
    build_model();
    @(negedge clk);
    clear_stats();
    t_start = cyc;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < t_start + 300) @(negedge clk);
    total++; if (class_o !== 4'(c1) || max_o !== m1) begin
      bad++; $display("FAIL b2b_hold: got %0d/%0d required %0d/%0d", class_o, $signed(max_o), c1, m1);
    end
    wait_done("b2b_second");
    total++; if (done_cyc != t_start + 671) begin bad++; $display("FAIL b2b_done_cycle: got T+%0d required T+671", done_cyc - t_start); end
    total++; if (class_at_done !== 4'(exp_class) || max_at_done !== exp_max) begin
      bad++; $display("FAIL b2b_second_result: got %0d/%0d required %0d/%0d", class_at_done, $signed(max_at_done), exp_class, exp_max);
    end
  endtask

  initial begin
    clear_stats();
    t_start = 0;
    test_reset();
    test_nominal();
    test_tie();
    test_all_negative();
    test_random();
    test_start_during_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
